fu_sched: RTL

FU_SCHED -- requirements
Module: fu_sched

---
 rtl/fu_sched_pkg.sv | 31 +++
 rtl/fu_lane_ctrl.sv | 70 +++++++
 rtl/fu_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/fu_sched_pkg.sv
// fu_sched_pkg -- shared definitions for the functional-unit scheduler slice.
//
// Contents:
//   `WAYS       number of issue lanes (and per-lane functional units)
//   `RS         reservation-station entry count used by the surrounding core
//   fu_state_e  per-lane FSM state (FU_IDLE / FU_BUSY / FU_DONE)
//   FU_MAX_LAT  default maximum operation latency in cycles
//
// The macros are guarded so a core-level definition takes precedence.

`ifndef FU_SCHED_DEFS_SV
`define FU_SCHED_DEFS_SV
`ifndef WAYS
`define WAYS 4
`endif
`ifndef RS
`define RS 8
`endif
`endif

package fu_sched_pkg;

    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_BUSY = 2'd1,
        FU_DONE = 2'd2
    } fu_state_e;

    localparam int FU_MAX_LAT = 8;

endpackage

// File: rtl/fu_lane_ctrl.sv
// fu_lane_ctrl -- per-lane functional-unit tracker.
//
// Holds one lane's FSM (IDLE -> BUSY -> DONE -> IDLE) and its latency
// down-counter. Issue acceptance is decided by the parent; this block
// only sequences the accepted operation until its result is granted.
//
// Ports:
//   clock  in   sole clock, all updates on posedge
//   reset  in   synchronous, active-low
//   flush  in   squash: lane returns to IDLE next cycle
//   grant  in   CDB accepted this lane's result (meaningful in DONE)
//   load   in   accepted issue this cycle (only asserted when lane is free)
//   lat    in   latency of the loaded operation, 1..MAX_LAT
//   state  out  current FSM state (fu_state_e encoding), registered

module fu_lane_ctrl
    import fu_sched_pkg::*;
#(
    parameter int LATW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            grant,
    input  logic            load,
    input  logic [LATW-1:0] lat,
    output logic [1:0]      state
);

    fu_state_e       state_q;
    logic [LATW-1:0] cnt;

    assign state = state_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FU_IDLE;
            cnt     <= '0;
        end else if (flush) begin
            state_q <= FU_IDLE;
            cnt     <= '0;
        end else if (load) begin
            // A one-cycle op is ready on the very next cycle, so it skips BUSY.
            if (lat == LATW'(1)) begin
                state_q <= FU_DONE;
                cnt     <= '0;
            end else begin
                state_q <= FU_BUSY;
                cnt     <= lat - LATW'(1);
            end
        end else begin
            case (state_q)
                FU_BUSY: begin
                    cnt <= cnt - LATW'(1);
                    if (cnt == LATW'(1)) begin
                        state_q <= FU_DONE;
                    end
                end
                FU_DONE: begin
                    if (grant) begin
                        state_q <= FU_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fu_sched.sv
// fu_sched -- functional-unit occupancy scheduler for WAYS issue lanes.
//
// Each lane tracks one in-flight operation from issue until its result is
// granted onto the CDB. fu_occupied is combinational so the reservation
// station can issue back-to-back into a lane in the cycle its result leaves.
//
// Handshake: an issue on lane i is accepted when issue_valid[i]=1,
// fu_occupied[i]=0, issue_lat[i] is in 1..MAX_LAT and flush=0. A result is
// offered while done_valid[i]=1 and leaves in the cycle cdb_grant[i]=1.
//
// Ports:
//   clock        in   sole clock
//   reset        in   synchronous, active-low
//   issue_valid  in   [WAYS]       operation offered on lane i
//   issue_lat    in   [WAYS*LATW]  lane-i latency, lane i at [i*LATW +: LATW]
//   cdb_grant    in   [WAYS]       CDB takes lane-i result
//   flush        in   kill all in-flight operations
//   fu_occupied  out  [WAYS]       lane busy
//   done_valid   out  [WAYS]       lane-i result waiting for the CDB
//   issue_err    out  sticky protocol-violation flag, cleared only by reset
//   perf_issued  out  [32]  (FU_SCHED_PERF_EN only) accepted-issue count
//   perf_stall   out  [32]  (FU_SCHED_PERF_EN only) DONE-ungranted lane-cycles
//
// Build option: define FU_SCHED_PERF_EN to add the performance counters.

module fu_sched
    import fu_sched_pkg::*;
#(
    parameter int  WAYS    = `WAYS,
    parameter int  MAX_LAT = FU_MAX_LAT,
    localparam int LATW    = $clog2(MAX_LAT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WAYS-1:0]      issue_valid,
    input  logic [WAYS*LATW-1:0] issue_lat,
    input  logic [WAYS-1:0]      cdb_grant,
    input  logic                 flush,
    output logic [WAYS-1:0]      fu_occupied,
    output logic [WAYS-1:0]      done_valid,
    output logic                 issue_err
`ifdef FU_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    logic [1:0]      lane_state [WAYS];
    logic [WAYS-1:0] in_done;
    logic [WAYS-1:0] lat_ok;
    logic [WAYS-1:0] accept;
    logic [WAYS-1:0] err_lane;

    for (genvar i = 0; i < WAYS; i++) begin : g_lane
        logic [LATW-1:0] lat_i;

        assign lat_i      = issue_lat[i*LATW +: LATW];
        assign in_done[i] = (lane_state[i] == FU_DONE);
        assign done_valid[i] = in_done[i];

        // A grant under flush does not free the lane: flush wins, and the
        // lane is already being cleared, so no re-issue may slip in.
        assign fu_occupied[i] = (lane_state[i] != FU_IDLE)
                              & ~(in_done[i] & cdb_grant[i] & ~flush);

        assign lat_ok[i] = (lat_i != '0) && (int'(lat_i) <= MAX_LAT);
        assign accept[i] = issue_valid[i] & ~fu_occupied[i] & lat_ok[i] & ~flush;

        // Issues dropped only because of flush are legal squashes, not errors.
        assign err_lane[i] = (issue_valid[i] & ~flush & (fu_occupied[i] | ~lat_ok[i]))
                           | (cdb_grant[i] & ~in_done[i]);

        fu_lane_ctrl #(
            .LATW (LATW)
        ) u_lane (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .grant (cdb_grant[i]),
            .load  (accept[i]),
            .lat   (lat_i),
            .state (lane_state[i])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            issue_err <= 1'b0;
        end else if (|err_lane) begin
            issue_err <= 1'b1;
        end
    end

`ifdef FU_SCHED_PERF_EN
    logic [WAYS-1:0] stall_lane;

    assign stall_lane = in_done & ~cdb_grant;

    // Plain 32-bit adders: wrap modulo 2^32 by construction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            perf_issued <= perf_issued + 32'($countones(accept));
            perf_stall  <= perf_stall + 32'($countones(stall_lane));
        end
    end
`endif

endmodule
